// File: rtl/apu_pkg.sv
// Shared definitions for the sound-effect scheduler.
// Holds the effect ids, the scheduler state encoding, the constant effect
// table (periods, levels, durations, noise flags), the jingle note ROM and
// the fixed-priority helpers. No ports; imported by the interface and RTL.
package apu_pkg;

    // Effect ids as seen on active_id.
    localparam logic [1:0] SFX_HURT   = 2'd0;
    localparam logic [1:0] SFX_HIT    = 2'd1;
    localparam logic [1:0] SFX_SHEEP  = 2'd2;
    localparam logic [1:0] SFX_JINGLE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } sfx_state_e;

    localparam int FRAMES_W = 5;

    // Effect table.
    localparam logic [15:0] PERIOD_HURT  = 16'd200;
    localparam logic [15:0] PERIOD_HIT   = 16'd0;
    localparam logic [15:0] PERIOD_SHEEP = 16'd600;

    localparam logic [3:0] LEVEL_HURT   = 4'd12;
    localparam logic [3:0] LEVEL_HIT    = 4'd10;
    localparam logic [3:0] LEVEL_SHEEP  = 4'd8;
    localparam logic [3:0] LEVEL_JINGLE = 4'd14;

    localparam logic [FRAMES_W-1:0] FRAMES_HURT  = 5'd6;
    localparam logic [FRAMES_W-1:0] FRAMES_HIT   = 5'd4;
    localparam logic [FRAMES_W-1:0] FRAMES_SHEEP = 5'd10;

    localparam logic NOISE_HURT   = 1'b0;
    localparam logic NOISE_HIT    = 1'b1;
    localparam logic NOISE_SHEEP  = 1'b0;
    localparam logic NOISE_JINGLE = 1'b0;

    // Game-end jingle, one half-period per note.
    localparam logic [15:0] JINGLE_ROM [4] = '{16'd600, 16'd400, 16'd500, 16'd700};

    // Priority rank, 0 is most urgent: jingle > hurt > hit > sheep.
    function automatic logic [1:0] sfx_rank(input logic [1:0] id);
        return (id == SFX_JINGLE) ? 2'd0 : id + 2'd1;
    endfunction

    // Highest-priority id present in a request vector (caller checks |req).
    function automatic logic [1:0] sfx_pick(input logic [3:0] req);
        logic [1:0] id;
        id = SFX_HURT;
        if (req[SFX_JINGLE])     id = SFX_JINGLE;
        else if (req[SFX_HURT])  id = SFX_HURT;
        else if (req[SFX_HIT])   id = SFX_HIT;
        else if (req[SFX_SHEEP]) id = SFX_SHEEP;
        return id;
    endfunction

endpackage

// File: rtl/sfx_scheduler_if.sv
// Bundle between the game logic and the sound-effect scheduler.
// master: game side (drives frame_tick and the request pulses, sees the voice)
// slave : scheduler side (drives the voice configuration and debug state)
// Signalling: frame_tick and req_* are single-cycle pulses sampled on the
// rising clock edge; there is no back-pressure, a pulse the scheduler cannot
// accept is simply dropped. Voice outputs are registered and change only on
// clock edges; active_id is meaningful only while voice_on is high.
interface sfx_scheduler_if #(
    parameter int PERIOD_W = 16
);
    import apu_pkg::*;

    logic                frame_tick;
    logic                req_hurt;
    logic                req_hit;
    logic                req_sheep;
    logic                req_jingle;
    logic                voice_on;
    logic                voice_noise;
    logic [PERIOD_W-1:0] voice_period;
    logic [3:0]          voice_level;
    logic [1:0]          active_id;
    logic                busy;
    sfx_state_e          dbg_state;

    modport master (
        output frame_tick, req_hurt, req_hit, req_sheep, req_jingle,
        input  voice_on, voice_noise, voice_period, voice_level, active_id, busy, dbg_state
    );

    modport slave (
        input  frame_tick, req_hurt, req_hit, req_sheep, req_jingle,
        output voice_on, voice_noise, voice_period, voice_level, active_id, busy, dbg_state
    );
endinterface

// File: rtl/sfx_cooldown_timer.sv
// Per-source cooldown counter, counted in video frames.
// Ports: clk, reset (sync, active-high), frame_tick_i (frame pulse),
// load_i (restart at COOLDOWN_FRAMES), zero_o (source may be accepted).
// The counter stops at zero; a load wins over a same-edge frame decrement.
module sfx_cooldown_timer #(
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick_i,
    input  logic load_i,
    output logic zero_o
);
    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i)
            count_d = CW'(COOLDOWN_FRAMES);
        else if (frame_tick_i && count_q != '0)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign zero_o = (count_q == '0);
endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler for the single APU voice.
// Latches request pulses, arbitrates by fixed priority, applies per-source
// cooldowns, times effects in frames and steps the 4-note jingle.
// Ports: clk, reset (sync, active-high), bus (sfx_scheduler_if.slave):
// frame_tick/req_* in; voice_on/noise/period/level, active_id, busy and
// dbg_state out, all registered.
module sfx_scheduler
    import apu_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = 8,
    parameter int NOTE_FRAMES     = 8,
    parameter int PERIOD_W        = 16
) (
    input  logic            clk,
    input  logic            reset,
    sfx_scheduler_if.slave  bus
);
    sfx_state_e          state_q;
    logic [3:0]          pending_q;
    logic [FRAMES_W-1:0] frames_left_q;
    logic [1:0]          note_idx_q;
    logic                voice_on_q, voice_noise_q;
    logic [PERIOD_W-1:0] voice_period_q;
    logic [3:0]          voice_level_q;
    logic [1:0]          active_id_q;

    logic [3:0] req_v, playing_v, blocked, eff_req, cd_zero, cd_load, grant_mask;
    logic [1:0] grant_id, next_note;
    logic       note_end, jingle_more, do_end, do_preempt, do_grant;

    logic                g_noise;
    logic [15:0]         g_period;
    logic [3:0]          g_level;
    logic [FRAMES_W-1:0] g_frames;

    assign req_v = {bus.req_jingle, bus.req_sheep, bus.req_hit, bus.req_hurt};

    // A pulse from a source in cooldown, or from the effect now playing,
    // is dropped rather than queued.
    assign playing_v = voice_on_q ? (4'b0001 << active_id_q) : 4'b0000;
    assign blocked   = ~cd_zero | playing_v;
    assign eff_req   = pending_q | (req_v & ~blocked);
    assign grant_id  = sfx_pick(eff_req);

    assign note_end    = (state_q == ST_PLAY) && bus.frame_tick && (frames_left_q == 5'd1);
    assign jingle_more = (active_id_q == SFX_JINGLE) && (note_idx_q != 2'd3);
    assign next_note   = note_idx_q + 2'd1;
    assign do_end      = note_end && !jingle_more;
    // An ending effect takes priority over preemption: the newcomer stays
    // pending and plays after the gap.
    assign do_preempt  = (state_q == ST_PLAY) && !note_end && (|eff_req) &&
                         (sfx_rank(grant_id) < sfx_rank(active_id_q));
    assign do_grant    = ((state_q == ST_IDLE) && (|eff_req)) || do_preempt;
    assign grant_mask  = do_grant ? (4'b0001 << grant_id) : 4'b0000;
    assign cd_load     = (do_end || do_preempt) ? (4'b0001 << active_id_q) : 4'b0000;

    always_comb begin
        g_noise  = 1'b0;
        g_period = '0;
        g_level  = '0;
        g_frames = '0;
        case (grant_id)
            SFX_HURT: begin
                g_noise = NOISE_HURT;  g_period = PERIOD_HURT;
                g_level = LEVEL_HURT;  g_frames = FRAMES_HURT;
            end
            SFX_HIT: begin
                g_noise = NOISE_HIT;   g_period = PERIOD_HIT;
                g_level = LEVEL_HIT;   g_frames = FRAMES_HIT;
            end
            SFX_SHEEP: begin
                g_noise = NOISE_SHEEP; g_period = PERIOD_SHEEP;
                g_level = LEVEL_SHEEP; g_frames = FRAMES_SHEEP;
            end
            default: begin
                g_noise = NOISE_JINGLE; g_period = JINGLE_ROM[0];
                g_level = LEVEL_JINGLE; g_frames = FRAMES_W'(NOTE_FRAMES);
            end
        endcase
    end

    for (genvar i = 0; i < 4; i++) begin : g_cd
        sfx_cooldown_timer #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_cd (
            .clk          (clk),
            .reset        (reset),
            .frame_tick_i (bus.frame_tick),
            .load_i       (cd_load[i]),
            .zero_o       (cd_zero[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            pending_q      <= '0;
            frames_left_q  <= '0;
            note_idx_q     <= '0;
            voice_on_q     <= 1'b0;
            voice_noise_q  <= 1'b0;
            voice_period_q <= '0;
            voice_level_q  <= '0;
            active_id_q    <= '0;
        end else begin
            pending_q <= eff_req & ~grant_mask;
            if (do_grant) begin
                // Fresh grant from IDLE or a direct hand-over on preemption.
                state_q        <= ST_PLAY;
                voice_on_q     <= 1'b1;
                voice_noise_q  <= g_noise;
                voice_period_q <= PERIOD_W'(g_period);
                voice_level_q  <= g_level;
                active_id_q    <= grant_id;
                frames_left_q  <= g_frames;
                note_idx_q     <= '0;
            end else begin
                case (state_q)
                    ST_PLAY: begin
                        if (do_end) begin
                            state_q        <= ST_GAP;
                            voice_on_q     <= 1'b0;
                            voice_noise_q  <= 1'b0;
                            voice_period_q <= '0;
                            voice_level_q  <= '0;
                            active_id_q    <= '0;
                            frames_left_q  <= '0;
                            note_idx_q     <= '0;
                        end else if (note_end) begin
                            // Next jingle note, seamless.
                            note_idx_q     <= next_note;
                            voice_period_q <= PERIOD_W'(JINGLE_ROM[next_note]);
                            frames_left_q  <= FRAMES_W'(NOTE_FRAMES);
                        end else if (bus.frame_tick && frames_left_q != '0) begin
                            frames_left_q  <= frames_left_q - 5'd1;
                        end
                    end
                    ST_GAP:  state_q <= ST_IDLE;
                    default: ;
                endcase
            end
        end
    end

    assign bus.voice_on     = voice_on_q;
    assign bus.voice_noise  = voice_noise_q;
    assign bus.voice_period = voice_period_q;
    assign bus.voice_level  = voice_level_q;
    assign bus.active_id    = active_id_q;
    assign bus.busy         = voice_on_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_sfx_scheduler.sv
module tb_sfx_scheduler;
    localparam int COOLDOWN_FRAMES = 8;
    localparam int NOTE_FRAMES     = 8;
    localparam int PERIOD_W        = 16;
    localparam int FRAME_LEN       = 4;
    localparam int P_IDLE = 0, P_PLAY = 1, P_GAP = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sfx_scheduler_if #(.PERIOD_W(PERIOD_W)) bus();

    sfx_scheduler #(
        .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
        .NOTE_FRAMES     (NOTE_FRAMES),
        .PERIOD_W        (PERIOD_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running frame pulse, one cycle in every FRAME_LEN.
    int fcnt = 0;
    always @(negedge clk) begin
        fcnt = (fcnt == FRAME_LEN - 1) ? 0 : fcnt + 1;
        bus.frame_tick = (fcnt == 0);
    end

    // Frame ticks seen while the voice was on (pre-edge value).
    int on_ticks = 0;
    always @(posedge clk) if (!reset && bus.frame_tick && bus.voice_on) on_ticks++;

    // ---------------- scoreboard counters ----------------
    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    int t_period [4] = '{200, 0, 600, 0};
    int t_level  [4] = '{12, 10, 8, 14};
    int t_frames [4] = '{6, 4, 10, NOTE_FRAMES};
    int t_noise  [4] = '{0, 1, 0, 0};
    int jing     [4] = '{600, 400, 500, 700};

    int       m_phase;
    bit       m_on;
    int       m_id, m_left, m_note;
    int       m_cd [4];
    bit [3:0] m_pend;

    function automatic int prio(input int id);
        return (id == 3) ? 0 : id + 1;
    endfunction

    function automatic int top_of(input bit [3:0] w);
        int order [4] = '{3, 0, 1, 2};
        for (int k = 0; k < 4; k++) if (w[order[k]]) return order[k];
        return -1;
    endfunction

    function automatic void start_effect(input int id);
        m_on = 1'b1; m_id = id; m_note = 0; m_left = t_frames[id]; m_phase = P_PLAY;
    endfunction

    function automatic void model_reset();
        m_phase = P_IDLE; m_on = 1'b0; m_id = 0; m_left = 0; m_note = 0; m_pend = '0;
        for (int i = 0; i < 4; i++) m_cd[i] = 0;
    endfunction

    function automatic void model_step();
        bit [3:0] req, want;
        int best;
        req = {bus.req_jingle, bus.req_sheep, bus.req_hit, bus.req_hurt};
        for (int i = 0; i < 4; i++)
            want[i] = m_pend[i] | (req[i] && m_cd[i] == 0 && !(m_on && m_id == i));
        for (int i = 0; i < 4; i++) if (bus.frame_tick && m_cd[i] > 0) m_cd[i]--;
        best = top_of(want);
        case (m_phase)
            P_GAP:  m_phase = P_IDLE;
            P_IDLE: if (best >= 0) begin start_effect(best); want[best] = 1'b0; end
            default: begin
                if (bus.frame_tick && m_left == 1) begin
                    if (m_id == 3 && m_note < 3) begin
                        m_note++; m_left = NOTE_FRAMES;
                    end else begin
                        m_cd[m_id] = COOLDOWN_FRAMES; m_on = 1'b0; m_phase = P_GAP;
                    end
                end else begin
                    if (bus.frame_tick) m_left--;
                    if (best >= 0 && prio(best) < prio(m_id)) begin
                        m_cd[m_id] = COOLDOWN_FRAMES;
                        start_effect(best);
                        want[best] = 1'b0;
                    end
                end
            end
        endcase
        m_pend = want;
    endfunction

    always @(posedge clk) begin
        if (reset) model_reset();
        else       model_step();
    end

    function automatic int exp_period();
        if (!m_on) return 0;
        return (m_id == 3) ? jing[m_note] : t_period[m_id];
    endfunction

    // Compare process: every cycle once out of the first reset.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("voice_on",     bus.voice_on,     m_on);
            chk("busy",         bus.busy,         m_on);
            chk("voice_noise",  bus.voice_noise,  m_on ? t_noise[m_id] : 0);
            chk("voice_period", bus.voice_period, exp_period());
            chk("voice_level",  bus.voice_level,  m_on ? t_level[m_id] : 0);
            chk("active_id",    bus.active_id,    m_on ? m_id : 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input logic [3:0] r);
        {bus.req_jingle, bus.req_sheep, bus.req_hit, bus.req_hurt} = r;
    endtask

    // r bits: 0 hurt, 1 hit, 2 sheep, 3 jingle. Returns one cycle after capture.
    task automatic pulse(input logic [3:0] r);
        @(negedge clk); set_req(r);
        @(negedge clk); set_req(4'b0000);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_voice(input string name, input bit want, input int max, output int n);
        n = 0;
        while (bus.voice_on !== want && n < max) begin @(negedge clk); n++; end
        chk(name, bus.voice_on, want);
    endtask

    task automatic wait_period(input string name, input int val, input int max);
        int n = 0;
        while (bus.voice_period != val && n < max) begin @(negedge clk); n++; end
        chk(name, bus.voice_period, val);
    endtask

    // ---------------- stimulus ----------------
    int n, base;
    initial begin
        set_req(4'b0000);
        reset = 1'b1;
        idle(3);
        cmp_en = 1'b1;
        reset = 1'b0;
        chk("reset_voice_on", bus.voice_on, 0);
        chk("reset_period",   bus.voice_period, 0);
        chk("reset_level",    bus.voice_level, 0);
        chk("reset_id",       bus.active_id, 0);

        // Single hurt effect.
        pulse(4'b0001);
        base = on_ticks;
        chk("hurt_on", bus.voice_on, 1);
        chk("hurt_period", bus.voice_period, 200);
        chk("hurt_level", bus.voice_level, 12);
        chk("hurt_id", bus.active_id, 0);
        wait_voice("hurt_end", 1'b0, 200, n);
        chk("hurt_frames", on_ticks - base, 6);
        idle(40);

        // Sheep preempted by the jingle; jingle note stepping.
        pulse(4'b0100);
        idle(3);
        pulse(4'b1000);
        base = on_ticks;
        chk("preempt_id", bus.active_id, 3);
        chk("preempt_period", bus.voice_period, 600);
        chk("preempt_level", bus.voice_level, 14);
        chk("model_sheep_cd", m_cd[2], 8);
        wait_period("jingle_note1", 400, 60);
        chk("jingle_note1_frames", on_ticks - base, 8);
        wait_period("jingle_note2", 500, 60);
        chk("jingle_note2_frames", on_ticks - base, 16);
        wait_period("jingle_note3", 700, 60);
        chk("jingle_note3_frames", on_ticks - base, 24);
        wait_voice("jingle_end", 1'b0, 60, n);
        chk("jingle_frames", on_ticks - base, 32);
        idle(40);

        // Sheep queued behind hurt.
        pulse(4'b0001);
        idle(2);
        pulse(4'b0100);
        chk("queued_still_hurt", bus.active_id, 0);
        wait_voice("queued_hurt_end", 1'b0, 200, n);
        wait_voice("queued_sheep_on", 1'b1, 10, n);
        chk("queued_off_cycles", n, 2);
        base = on_ticks;
        chk("queued_sheep_id", bus.active_id, 2);
        chk("queued_sheep_period", bus.voice_period, 600);
        chk("queued_sheep_level", bus.voice_level, 8);
        wait_voice("queued_sheep_end", 1'b0, 200, n);
        chk("queued_sheep_frames", on_ticks - base, 10);
        idle(40);

        // Cooldown drop, then acceptance.
        pulse(4'b0010);
        chk("hit_noise", bus.voice_noise, 1);
        wait_voice("hit_end", 1'b0, 200, n);
        idle(3 * FRAME_LEN);
        pulse(4'b0010);
        chk("hit_cooldown_drop", bus.voice_on, 0);
        idle(40);
        pulse(4'b0010);
        chk("hit_after_cooldown", bus.voice_on, 1);
        chk("hit_after_level", bus.voice_level, 10);
        wait_voice("hit2_end", 1'b0, 200, n);
        idle(40);

        // Simultaneous requests.
        pulse(4'b0111);
        chk("simul_first", bus.active_id, 0);
        wait_voice("simul_hurt_end", 1'b0, 200, n);
        wait_voice("simul_hit_on", 1'b1, 10, n);
        chk("simul_second", bus.active_id, 1);
        wait_voice("simul_hit_end", 1'b0, 200, n);
        wait_voice("simul_sheep_on", 1'b1, 10, n);
        chk("simul_third", bus.active_id, 2);
        wait_voice("simul_sheep_end", 1'b0, 200, n);
        idle(40);

        // Reset in the middle of a jingle.
        pulse(4'b0100);
        idle(3);
        pulse(4'b1000);
        idle(10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_voice_on", bus.voice_on, 0);
        chk("rst_mid_period", bus.voice_period, 0);
        chk("rst_mid_level", bus.voice_level, 0);
        pulse(4'b0100);
        chk("rst_sheep_cd_cleared", bus.active_id, 2);
        pulse(4'b1000);
        chk("rst_jingle_accept", bus.active_id, 3);
        chk("rst_jingle_period", bus.voice_period, 600);
        idle(200);

        // Randomised traffic, checked by the compare process.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 599) == 0);
            set_req({($urandom_range(0, 59) == 0), ($urandom_range(0, 29) == 0),
                     ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0)});
        end
        @(negedge clk);
        reset = 1'b0;
        set_req(4'b0000);
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
